// File: rtl/sa_pkg.sv
// Shared definitions for the Shift_and_Add bit scheduler: width derivations
// and the sequencer state encoding.
package sa_pkg;

   function automatic int adc_precision_f(input int bit_cell, input int bit_dac, input int ouy);
      if (bit_cell == 1 || bit_dac == 1)
         return bit_cell + bit_dac + $clog2(ouy) - 1;
      return bit_cell + bit_dac + $clog2(ouy);
   endfunction

   function automatic int bit_sa_f(input int adc_precision, input int bit_w, input int bit_ifm);
      return adc_precision + bit_w + bit_ifm - 1;
   endfunction

   function automatic int bit_acc_f(input int bit_sa, input int bit_w, input int bit_ifm);
      return bit_sa + $clog2(bit_ifm * bit_w);
   endfunction

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_ACC   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_REQ   = ST_REQ,
      S_ISSUE = ST_ISSUE,
      S_WAIT  = ST_WAIT,
      S_ACC   = ST_ACC,
      S_DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/sa_pos_counter.sv
// Nested (input bit, weight bit) position counter: wb is the inner loop,
// ib the outer one; last flags the final pair of a column.
module sa_pos_counter #(
   parameter int BIT_IFM = 8,
   parameter int BIT_W   = 8,
   localparam int IB_W   = $clog2(BIT_IFM),
   localparam int WB_W   = $clog2(BIT_W)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            inc,
   output logic [IB_W-1:0] ib,
   output logic [WB_W-1:0] wb,
   output logic            last
);

   logic wb_last;

   assign wb_last = (wb == WB_W'(BIT_W - 1));
   assign last    = wb_last && (ib == IB_W'(BIT_IFM - 1));

   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge values, independent of statement order inside the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ib <= '0;
         wb <= '0;
      end else if (clr) begin
         ib <= '0;
         wb <= '0;
      end else if (inc) begin
         if (wb_last) begin
            wb <= '0;
            ib <= ib + IB_W'(1);
         end else begin
            wb <= wb + WB_W'(1);
         end
      end
   end

endmodule

// File: rtl/sa_bit_scheduler.sv
// Sequencer that walks every (input bit, weight bit) pair of one MAC column
// through a single Shift_and_Add instance and accumulates the signed results.
module sa_bit_scheduler
   import sa_pkg::*;
#(
   parameter int BIT_CELL     = 1,
   parameter int BIT_DAC      = 1,
   parameter int BIT_W        = 8,
   parameter int OUY          = 32,
   parameter int BIT_IFM      = 8,
   localparam int ADC_PRECISION = adc_precision_f(BIT_CELL, BIT_DAC, OUY),
   localparam int BIT_SA        = bit_sa_f(ADC_PRECISION, BIT_W, BIT_IFM),
   localparam int BIT_ACC       = bit_acc_f(BIT_SA, BIT_W, BIT_IFM),
   localparam int OC_W          = $clog2(OUY),
   localparam int IB_W          = $clog2(BIT_IFM),
   localparam int WB_W          = $clog2(BIT_W)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [OC_W-1:0]          ones_counter_in,
   output logic                     adc_req,
   input  logic                     adc_valid,
   input  logic [ADC_PRECISION-1:0] adc_data,
   output logic                     sa_in_valid,
   output logic [ADC_PRECISION-1:0] sa_adc_result,
   output logic [BIT_W-1:0]         sa_weight_pos,
   output logic [OC_W-1:0]          sa_ones_counter,
   output logic [IB_W-1:0]          sa_input_pos,
   input  logic                     sa_out_valid,
   input  logic signed [BIT_SA-1:0] sa_result,
   output logic                     busy,
   output logic                     done,
   output logic [BIT_ACC-1:0]       acc_out,
   output logic                     err_spurious
);

   state_t                     state, next_state;
   logic [IB_W-1:0]            ib;
   logic [WB_W-1:0]            wb;
   logic                       last;
   logic                       start_ok;
   logic                       pos_inc;
   logic                       take_adc;
   logic                       take_res;
   logic                       finish;
   logic [OC_W-1:0]            ones_q;
   logic signed [BIT_SA-1:0]   res_q;
   logic signed [BIT_ACC-1:0]  acc;

   assign start_ok = (state == S_IDLE) && start && !abort;
   assign pos_inc  = (state == S_ACC) && !abort;
   assign take_adc = (state == S_REQ) && (next_state == S_ISSUE);
   assign take_res = (state == S_WAIT) && (next_state == S_ACC);
   assign finish   = (state == S_DONE) && !abort;

   sa_pos_counter #(
      .BIT_IFM (BIT_IFM),
      .BIT_W   (BIT_W)
   ) u_pos (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_ok),
      .inc   (pos_inc),
      .ib    (ib),
      .wb    (wb),
      .last  (last)
   );

   // NOTE: next_state gets its default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start)        next_state = S_REQ;
         S_REQ:   if (adc_valid)    next_state = S_ISSUE;
         S_ISSUE:                   next_state = S_WAIT;
         S_WAIT:  if (sa_out_valid) next_state = S_ACC;
         S_ACC:                     next_state = last ? S_DONE : S_REQ;
         S_DONE:                    next_state = S_IDLE;
         default:                   next_state = S_IDLE;
      endcase
      if (abort)
         next_state = S_IDLE;
   end

   // Control outputs are decoded from next_state so they line up with the
   // state they describe while still coming straight out of flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         adc_req         <= 1'b0;
         sa_in_valid     <= 1'b0;
         sa_adc_result   <= '0;
         sa_weight_pos   <= '0;
         sa_ones_counter <= '0;
         sa_input_pos    <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         acc_out         <= '0;
         err_spurious    <= 1'b0;
         ones_q          <= '0;
         res_q           <= '0;
         acc             <= '0;
      end else begin
         state        <= next_state;
         adc_req      <= (next_state == S_REQ);
         sa_in_valid  <= (next_state == S_ISSUE);
         busy         <= (next_state != S_IDLE);
         done         <= finish;
         err_spurious <= err_spurious | (sa_out_valid && (state != S_WAIT));

         if (start_ok) begin
            ones_q <= ones_counter_in;
            acc    <= '0;
         end

         // Payload only changes on entry to ISSUE, so it is stable under sa_in_valid.
         if (take_adc) begin
            sa_adc_result   <= adc_data;
            sa_weight_pos   <= BIT_W'(wb);
            sa_input_pos    <= ib;
            sa_ones_counter <= ones_q;
         end

         if (take_res)
            res_q <= sa_result;

         if (pos_inc)
            acc <= acc + BIT_ACC'(res_q);

         if (finish)
            acc_out <= acc;
      end
   end

endmodule

// File: tb/tb_sa_bit_scheduler.sv
// Self-checking bench for sa_bit_scheduler with ADC and Shift_and_Add
// responders and a column-level reference model.
module tb_sa_bit_scheduler;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               abort;
   logic [4:0]         ones_counter_in;
   logic               adc_req;
   logic               adc_valid;
   logic [5:0]         adc_data;
   logic               sa_in_valid;
   logic [5:0]         sa_adc_result;
   logic [7:0]         sa_weight_pos;
   logic [4:0]         sa_ones_counter;
   logic [2:0]         sa_input_pos;
   logic               sa_out_valid;
   logic signed [20:0] sa_result;
   logic               busy;
   logic               done;
   logic [26:0]        acc_out;
   logic               err_spurious;

   sa_bit_scheduler dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .abort           (abort),
      .ones_counter_in (ones_counter_in),
      .adc_req         (adc_req),
      .adc_valid       (adc_valid),
      .adc_data        (adc_data),
      .sa_in_valid     (sa_in_valid),
      .sa_adc_result   (sa_adc_result),
      .sa_weight_pos   (sa_weight_pos),
      .sa_ones_counter (sa_ones_counter),
      .sa_input_pos    (sa_input_pos),
      .sa_out_valid    (sa_out_valid),
      .sa_result       (sa_result),
      .busy            (busy),
      .done            (done),
      .acc_out         (acc_out),
      .err_spurious    (err_spurious)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Shift_and_Add stand-in: result depends on the issued pair according to mode.
   function automatic logic signed [20:0] sa_fn(input int mode, input int ib, input int wb);
      int v;
      case (mode)
         0:       v = 1;
         1:       v = -5;
         default: v = ib * 8 + wb - 30;
      endcase
      return 21'(v);
   endfunction

   // Column model and responder configuration
   int     mode      = 0;
   int     adc_delay = 0;
   int     adc_val   = 0;
   int     exp_ib[64];
   int     exp_wb[64];
   int     exp_n     = 0;
   int     exp_ones  = 0;
   int     exp_adc   = 0;
   longint exp_acc   = 0;
   int     exp_lat   = 0;
   int     op_idx    = 0;
   int     start_cyc = 0;
   int     done_cyc  = 0;
   bit     done_exp  = 0;
   bit     done_seen = 0;
   bit     prev_iv   = 0;
   bit     sa_ov_model = 0;
   bit     sa_ov_force = 0;
   int     sa_pend   = 0;
   int     req_cnt   = 0;

   assign sa_out_valid = sa_ov_model | sa_ov_force;

   // ADC and Shift_and_Add responders (latency 4: in_valid at t, out_valid at t+4)
   always @(negedge clk) begin
      if (!busy) sa_pend = 0;
      if (sa_pend > 0) begin
         sa_pend--;
         sa_ov_model = (sa_pend == 0);
      end else begin
         sa_ov_model = 1'b0;
      end
      if (sa_in_valid) begin
         sa_pend   = 4;
         sa_result = sa_fn(mode, int'(sa_input_pos), int'(sa_weight_pos));
      end
      if (adc_req) begin
         adc_valid = (req_cnt >= adc_delay);
         req_cnt++;
      end else begin
         req_cnt   = 0;
         adc_valid = (adc_delay == 0);
      end
      adc_data = 6'(adc_val);
   end

   // Compare process: every issue and every done pulse against the model
   always @(negedge clk) begin
      if (sa_in_valid) begin
         check("in_valid_width", longint'(prev_iv), 0);
         if (op_idx >= exp_n) begin
            check("extra_issue", op_idx, exp_n - 1);
         end else begin
            check($sformatf("input_pos[%0d]", op_idx), sa_input_pos, exp_ib[op_idx]);
            check($sformatf("weight_pos[%0d]", op_idx), sa_weight_pos, exp_wb[op_idx]);
            check($sformatf("ones[%0d]", op_idx), sa_ones_counter, exp_ones);
            check($sformatf("adc[%0d]", op_idx), sa_adc_result, exp_adc);
         end
         op_idx++;
      end
      if (done) begin
         if (!done_exp) begin
            check("unexpected_done", longint'(done), 0);
         end else begin
            done_cyc = cyc - start_cyc;
            check("acc_model", longint'($signed(acc_out)), exp_acc);
            check("done_latency", done_cyc, exp_lat);
            done_seen = 1;
            done_exp  = 0;
         end
      end
      prev_iv = sa_in_valid;
   end

   task automatic setup(input int mode_i, input int ones_i, input int delay_i, input int adc_i);
      int k = 0;
      mode      = mode_i;
      adc_delay = delay_i;
      adc_val   = adc_i;
      exp_ones  = ones_i;
      exp_adc   = adc_i;
      exp_acc   = 0;
      for (int ib = 0; ib < 8; ib++) begin
         for (int wb = 0; wb < 8; wb++) begin
            exp_ib[k] = ib;
            exp_wb[k] = wb;
            exp_acc  += longint'(sa_fn(mode_i, ib, wb));
            k++;
         end
      end
      exp_n     = k;
      exp_lat   = k * (7 + delay_i) + 1;
      op_idx    = 0;
      done_seen = 0;
      ones_counter_in = 5'(ones_i);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      start_cyc = cyc;
      ones_counter_in = ~ones_counter_in;
   endtask

   task automatic run_column(input string tag, input int mode_i, input int ones_i, input int delay_i,
                             input int adc_i, input int inject, input int lat_lit, input longint acc_lit);
      setup(mode_i, ones_i, delay_i, adc_i);
      done_exp = 1;
      pulse_start();
      if (inject > 0) begin
         repeat (inject) @(negedge clk);
         start = 1'b1;
         ones_counter_in = 5'd31;
         @(negedge clk);
         start = 1'b0;
      end
      for (int k = 0; k < 2000 && !done_seen; k++) @(negedge clk);
      @(negedge clk);
      check({tag, "_done_seen"}, longint'(done_seen), 1);
      check({tag, "_issues"}, op_idx, 64);
      check({tag, "_latency"}, done_cyc, lat_lit);
      check({tag, "_acc"}, longint'($signed(acc_out)), acc_lit);
      check({tag, "_busy_after"}, longint'(busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      ones_counter_in = '0;
      adc_valid = 1'b0;
      adc_data  = '0;
      sa_result = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_adc_req", longint'(adc_req), 0);
      check("rst_in_valid", longint'(sa_in_valid), 0);
      check("rst_acc_out", acc_out, 0);
      check("rst_err", longint'(err_spurious), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // T1..T4: full columns under different result patterns and ADC timing
      run_column("t1", 0, 3, 0, 1, 0, 449, 64);
      run_column("t2", 1, 31, 0, 42, 0, 449, -320);
      check("t2_acc_bits", acc_out, 27'h7FFFEC0);
      run_column("t3", 2, 3, 0, 63, 0, 449, 96);
      run_column("t4", 0, 3, 3, 1, 0, 641, 64);

      // T5: abort in WAIT of the tenth operation
      setup(1, 9, 0, 5);
      done_exp = 0;
      pulse_start();
      for (int k = 0; k < 200 && op_idx < 10; k++) @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_busy", longint'(busy), 0);
      check("t5_adc_req", longint'(adc_req), 0);
      check("t5_in_valid", longint'(sa_in_valid), 0);
      repeat (10) @(negedge clk);
      check("t5_no_done", longint'(done_seen), 0);
      check("t5_acc_kept", longint'($signed(acc_out)), 64);
      check("t5_issues_stopped", op_idx, 10);
      check("t5_err_clear", longint'(err_spurious), 0);
      run_column("t5_restart", 1, 9, 0, 5, 0, 449, -320);

      // T6: start while busy is dropped; spurious result is sticky until reset
      run_column("t6", 0, 5, 0, 7, 30, 449, 64);
      check("t6_err_before", longint'(err_spurious), 0);
      @(negedge clk);
      sa_ov_force = 1'b1;
      @(negedge clk);
      sa_ov_force = 1'b0;
      check("t6_err_set", longint'(err_spurious), 1);
      repeat (5) @(negedge clk);
      check("t6_err_sticky", longint'(err_spurious), 1);

      // Reset in the middle of a column
      setup(2, 11, 0, 3);
      done_exp = 0;
      pulse_start();
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", longint'(busy), 0);
      check("midrst_adc_req", longint'(adc_req), 0);
      check("midrst_in_valid", longint'(sa_in_valid), 0);
      check("midrst_acc_out", acc_out, 0);
      check("midrst_err", longint'(err_spurious), 0);
      check("midrst_ones", sa_ones_counter, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_idle", longint'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
